rv_rr_arbiter: RTL

- Shares one ready/valid egress stream among NUM_REQ ready/valid requesters using round-robin arbitration with burst locking.
- A grant is held until the granted requester's last beat is accepted, or until MAX_BURST beats have been accepted.
- Egress is driven from a one-entry output register.
- Sits in front of the team's buffered egress paths wherever several producers feed one 8-bit stream.

---
 rtl/rv_arb_pkg.sv | 15 +
 rtl/rv_rr_arbiter_rr_pick.sv | 30 +++
 rtl/rv_rr_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rv_arb_pkg.sv
// Shared definitions for the ready/valid round-robin arbiter and related schedulers.
// Holds the arbiter state encoding and the wrap-around index helper.
package rv_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Wrap explicitly at n-1 so non-power-of-two requester counts rotate correctly.
  function automatic int unsigned rr_next_idx(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rv_rr_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request at or after ptr,
// scanning upward with wrap. Purely combinational.
module rr_pick
  import rv_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] k;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[k]) begin
        found = 1'b1;
        idx   = k;
      end
      k = IDX_W'(rr_next_idx(32'(k), NUM_REQ));
    end
  end

endmodule

// File: rtl/rv_rr_arbiter.sv
// Round-robin ready/valid arbiter with burst locking feeding one registered egress stage.
// A grant lasts until the requester's last beat or MAX_BURST accepted beats.
module rv_rr_arbiter
  import rv_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic                        e_valid,
  input  logic                        e_ready,
  output logic [DATA_W-1:0]           e_data,
  output logic                        e_last,
  output logic [IDX_W-1:0]            e_src,
  output logic                        busy
);

  localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic               e_valid_q, e_valid_d;
  logic [DATA_W-1:0]  e_data_q, e_data_d;
  logic               e_last_q, e_last_d;
  logic [IDX_W-1:0]   e_src_q, e_src_d;

  logic               load_en;
  logic               accept;
  logic               burst_done;
  logic [CNT_W:0]     cnt_inc;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The egress slot can take a new beat when empty or draining this cycle.
  assign load_en    = !e_valid_q || e_ready;
  assign cnt_inc    = {1'b0, beat_cnt_q} + (CNT_W+1)'(1);
  assign burst_done = (MAX_BURST != 0) && (cnt_inc == (CNT_W+1)'(MAX_BURST));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    beat_cnt_d = beat_cnt_q;
    e_valid_d  = e_valid_q;
    e_data_d   = e_data_q;
    e_last_d   = e_last_q;
    e_src_d    = e_src_q;
    req_ready  = '0;
    accept     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (load_en && pick_found) begin
          gnt_d      = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        req_ready[gnt_q] = load_en;
        accept           = load_en && req_valid[gnt_q];
        if (accept) begin
          beat_cnt_d = cnt_inc[CNT_W-1:0];
          if (req_last[gnt_q] || burst_done) begin
            state_d = ARB_IDLE;
            ptr_d   = IDX_W'(rr_next_idx(32'(gnt_q), NUM_REQ));
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // A valid gap in the granted requester empties the slot rather than stalling it.
    if (load_en) begin
      e_valid_d = accept;
      if (accept) begin
        e_data_d = data_arr[gnt_q];
        e_last_d = req_last[gnt_q];
        e_src_d  = gnt_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      beat_cnt_q <= '0;
      e_valid_q  <= 1'b0;
      e_data_q   <= '0;
      e_last_q   <= 1'b0;
      e_src_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
      e_valid_q  <= e_valid_d;
      e_data_q   <= e_data_d;
      e_last_q   <= e_last_d;
      e_src_q    <= e_src_d;
    end
  end

  assign e_valid = e_valid_q;
  assign e_data  = e_data_q;
  assign e_last  = e_last_q;
  assign e_src   = e_src_q;
  assign busy    = (state_q == ARB_GRANT);

endmodule
